// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer row sink: pixel width, line-buffer
// bank count, copy FSM encoding and the frame-memory address packer.
package fb_pkg;

   localparam int PIX_W   = 24;
   localparam int N_BANKS = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_COPY = 1'b1
   } fsm_state_t;

   // Packs {frame, row, col} into a flat frame-memory address. Widths are
   // passed in so the caller can size-cast the result to its own bus width.
   function automatic logic [31:0] fm_pack(
      input logic        frame,
      input logic [15:0] row,
      input logic [15:0] col,
      input int          log_rows,
      input int          log_cols
   );
      return (32'(frame) << (log_rows + log_cols))
           | (32'(row)   << log_cols)
           |  32'(col);
   endfunction

endpackage

// File: rtl/fb_line_buf.sv
// Dual-bank line RAM: one write port and one read port, each with a bank
// select and a column address. Reads are registered (one cycle latency) and
// the read register holds its value while rd_en is low, so a stalled consumer
// can pick the data up later.
module fb_line_buf
   import fb_pkg::*;
#(
   parameter int N_COLS     = 64,
   parameter int LOG_N_COLS = $clog2(N_COLS)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic                  wr_bank,
   input  logic [LOG_N_COLS-1:0] wr_col,
   input  logic [PIX_W-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic                  rd_bank,
   input  logic [LOG_N_COLS-1:0] rd_col,
   output logic [PIX_W-1:0]      rd_data
);

   logic rd_bank_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N_BANKS; gi++) begin : g_bank
         logic [PIX_W-1:0] mem [N_COLS];
         logic [PIX_W-1:0] rd_q;

         // Per-bank storage: write when this bank is selected, read every
         // bank on rd_en and pick the right one on the output side.
         always_ff @(posedge clk) begin
            if (wr_en && (wr_bank == 1'(gi))) begin
               mem[wr_col] <= wr_data;
            end
            if (rd_en) begin
               rd_q <= mem[rd_col];
            end
         end
      end
   endgenerate

   // Remember which bank the held read data belongs to.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_bank_reg <= rd_bank;
      end
   end

   assign rd_data = rd_bank_reg ? g_bank[1].rd_q : g_bank[0].rd_q;

endmodule

// File: rtl/fb_row_sink.sv
// Receiving end of the frame-buffer write interface. Pixels land in a
// ping-pong pair of line buffers; a store command copies the back line into
// the double-buffered frame memory at the requested row, and frame flips are
// committed on the display's vertical sync.
module fb_row_sink
   import fb_pkg::*;
#(
   parameter int N_ROWS     = 64,
   parameter int N_COLS     = 64,
   parameter int LOG_N_ROWS = $clog2(N_ROWS),
   parameter int LOG_N_COLS = $clog2(N_COLS)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   // row store / line swap control
   input  logic [LOG_N_ROWS-1:0]                fbw_row_addr,
   input  logic                                 fbw_row_store,
   output logic                                 fbw_row_rdy,
   input  logic                                 fbw_row_swap,
   // pixel writes into the front line
   input  logic [PIX_W-1:0]                     fbw_data,
   input  logic [LOG_N_COLS-1:0]                fbw_col_addr,
   input  logic                                 fbw_wren,
   // frame flip
   input  logic                                 frame_swap,
   output logic                                 frame_rdy,
   input  logic                                 disp_vsync,
   output logic                                 disp_frame,
   // frame-memory write port
   output logic [LOG_N_ROWS+LOG_N_COLS:0]       fm_addr,
   output logic [PIX_W-1:0]                     fm_data,
   output logic                                 fm_wren,
   input  logic                                 fm_rdy
);

   localparam int FM_AW = 1 + LOG_N_ROWS + LOG_N_COLS;
   localparam logic [LOG_N_COLS:0] RD_TOTAL = (LOG_N_COLS+1)'(N_COLS);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   fsm_state_t                state_reg;
   logic                      front_sel_reg;   // bank currently taking pixel writes
   logic                      src_bank_reg;    // bank being copied out
   logic                      wr_frame_reg;    // frame being written by the host
   logic                      copy_frame_reg;  // wr_frame snapshot for the row in flight
   logic                      pending_reg;     // frame flip requested, not yet committed
   logic [LOG_N_ROWS-1:0]     row_reg;         // destination row of the copy
   logic [LOG_N_COLS:0]       rd_cnt_reg;      // reads issued so far in this copy
   logic [LOG_N_COLS-1:0]     ld_col_reg;      // column of the next beat to enter the output register
   logic                      s1_valid_reg;    // line RAM read register holds an unconsumed beat
   logic                      row_rdy_reg;
   logic                      fm_wren_reg;
   logic [FM_AW-1:0]          fm_addr_reg;
   logic [PIX_W-1:0]          fm_data_reg;

   // ---------------------------------------------------------------------
   // Control decode
   // ---------------------------------------------------------------------
   logic                      idle;
   logic                      start;
   logic                      do_swap;
   logic                      accept;
   logic                      out_free;
   logic                      s1_load;
   logic                      issue_copy;
   logic                      last_beat;
   logic                      commit;
   logic                      rd_en;
   logic                      rd_bank;
   logic [LOG_N_COLS-1:0]     rd_col;
   logic [PIX_W-1:0]          rd_data;
   logic [FM_AW-1:0]          fm_addr_next;

   assign idle     = (state_reg == ST_IDLE);
   assign start    = idle & fbw_row_store;
   assign do_swap  = idle & fbw_row_swap;

   // Output register handshake: a beat leaves when the memory takes it, and
   // the register can be refilled when it is empty or leaving this cycle.
   assign accept   = fm_wren_reg & fm_rdy;
   assign out_free = ~fm_wren_reg | accept;
   assign s1_load  = s1_valid_reg & out_free;

   // Keep the line RAM read register full whenever its beat is moving on.
   assign issue_copy = (state_reg == ST_COPY) && (rd_cnt_reg != RD_TOTAL)
                       && (~s1_valid_reg || out_free);

   // The final column leaving the output register ends the copy.
   assign last_beat = accept && (fm_addr_reg[LOG_N_COLS-1:0] == '1);

   // A flip never lands in the middle of a row copy.
   assign commit = disp_vsync & pending_reg & idle;

   // Column 0 is read in the store cycle itself so the first write appears
   // two cycles after the pulse. A swap in the same cycle applies first, so
   // the source is the line that was the front one before the pulse.
   assign rd_en   = start | issue_copy;
   assign rd_bank = start ? (fbw_row_swap ? front_sel_reg : ~front_sel_reg)
                          : src_bank_reg;
   assign rd_col  = start ? '0 : rd_cnt_reg[LOG_N_COLS-1:0];

   assign fm_addr_next = FM_AW'(fm_pack(copy_frame_reg, 16'(row_reg),
                                        16'(ld_col_reg), LOG_N_ROWS, LOG_N_COLS));

   // ---------------------------------------------------------------------
   // Line buffers: host writes the front bank, the copy reads the back bank
   // ---------------------------------------------------------------------
   fb_line_buf #(
      .N_COLS     (N_COLS),
      .LOG_N_COLS (LOG_N_COLS)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (fbw_wren),
      .wr_bank (front_sel_reg),
      .wr_col  (fbw_col_addr),
      .wr_data (fbw_data),
      .rd_en   (rd_en),
      .rd_bank (rd_bank),
      .rd_col  (rd_col),
      .rd_data (rd_data)
   );

   // Line swap: toggles only while idle; ignored while a copy runs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         front_sel_reg <= 1'b0;
      end else if (do_swap) begin
         front_sel_reg <= ~front_sel_reg;
      end
   end

   // Row-copy FSM with its read counter, output register and busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         src_bank_reg   <= 1'b0;
         copy_frame_reg <= 1'b0;
         row_reg        <= '0;
         rd_cnt_reg     <= '0;
         ld_col_reg     <= '0;
         s1_valid_reg   <= 1'b0;
         row_rdy_reg    <= 1'b1;
         fm_wren_reg    <= 1'b0;
         fm_addr_reg    <= '0;
         fm_data_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (fbw_row_store) begin
                  state_reg      <= ST_COPY;
                  row_reg        <= fbw_row_addr;
                  src_bank_reg   <= rd_bank;
                  copy_frame_reg <= wr_frame_reg;
                  rd_cnt_reg     <= (LOG_N_COLS+1)'(1);
                  ld_col_reg     <= '0;
                  s1_valid_reg   <= 1'b1;
                  row_rdy_reg    <= 1'b0;
               end
            end
            ST_COPY: begin
               if (issue_copy) begin
                  rd_cnt_reg   <= rd_cnt_reg + 1'b1;
                  s1_valid_reg <= 1'b1;
               end else if (s1_load) begin
                  s1_valid_reg <= 1'b0;
               end

               if (s1_load) begin
                  fm_wren_reg <= 1'b1;
                  fm_data_reg <= rd_data;
                  fm_addr_reg <= fm_addr_next;
                  ld_col_reg  <= ld_col_reg + 1'b1;
               end else if (accept) begin
                  fm_wren_reg <= 1'b0;
               end

               if (last_beat) begin
                  state_reg   <= ST_IDLE;
                  row_rdy_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Frame flip: latch a request, commit it on an idle vsync.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_frame_reg <= 1'b0;
         pending_reg  <= 1'b0;
      end else if (commit) begin
         wr_frame_reg <= ~wr_frame_reg;
         pending_reg  <= 1'b0;
      end else if (frame_swap) begin
         pending_reg  <= 1'b1;
      end
   end

   assign fbw_row_rdy = row_rdy_reg;
   assign frame_rdy   = ~pending_reg;
   assign disp_frame  = ~wr_frame_reg;
   assign fm_wren     = fm_wren_reg;
   assign fm_addr     = fm_addr_reg;
   assign fm_data     = fm_data_reg;

endmodule

// File: tb/tb_fb_row_sink.sv
// Directed bench for fb_row_sink: table of row-store scenarios plus
// hand-written frame-flip and reset-during-copy sequences.
module tb_fb_row_sink;

   localparam int N_ROWS = 64;
   localparam int N_COLS = 64;

   logic        clk;
   logic        rst;
   logic [5:0]  fbw_row_addr;
   logic        fbw_row_store;
   logic        fbw_row_rdy;
   logic        fbw_row_swap;
   logic [23:0] fbw_data;
   logic [5:0]  fbw_col_addr;
   logic        fbw_wren;
   logic        frame_swap;
   logic        frame_rdy;
   logic        disp_vsync;
   logic        disp_frame;
   logic [12:0] fm_addr;
   logic [23:0] fm_data;
   logic        fm_wren;
   logic        fm_rdy;

   int n_checks = 0;
   int n_fail   = 0;

   fb_row_sink #(
      .N_ROWS (N_ROWS),
      .N_COLS (N_COLS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fbw_row_addr  (fbw_row_addr),
      .fbw_row_store (fbw_row_store),
      .fbw_row_rdy   (fbw_row_rdy),
      .fbw_row_swap  (fbw_row_swap),
      .fbw_data      (fbw_data),
      .fbw_col_addr  (fbw_col_addr),
      .fbw_wren      (fbw_wren),
      .frame_swap    (frame_swap),
      .frame_rdy     (frame_rdy),
      .disp_vsync    (disp_vsync),
      .disp_frame    (disp_frame),
      .fm_addr       (fm_addr),
      .fm_data       (fm_data),
      .fm_wren       (fm_wren),
      .fm_rdy        (fm_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          fill;
      logic [23:0] base;
      bit          swap_before;
      bit          swap_with;
      logic [5:0]  row;
      bit          bp;
      bit          inject;
      logic [23:0] exp_base;
      int          exp_first;
      int          exp_low;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fill(input logic [23:0] base);
      for (int c = 0; c < N_COLS; c++) begin
         fbw_wren     = 1'b1;
         fbw_col_addr = 6'(c);
         fbw_data     = base + 24'(c);
         @(negedge clk);
      end
      fbw_wren = 1'b0;
   endtask

   task automatic pulse_swap();
      fbw_row_swap = 1'b1;
      @(negedge clk);
      fbw_row_swap = 1'b0;
   endtask

   // Issue one store and follow it to completion, checking every beat.
   task automatic do_store(input logic [5:0] row, input bit swap_with, input bit bp,
                           input bit inject, input int vsync_at,
                           input logic [23:0] exp_base, input logic exp_msb,
                           input int exp_first, input int exp_low);
      int          cyc;
      int          beat;
      int          low;
      int          first;
      bit          held;
      logic [12:0] h_addr;
      logic [23:0] h_data;
      logic [12:0] e_addr;
      logic [3:0]  pat;
      pat  = 4'b1001;
      held = 1'b0;
      fbw_row_addr  = row;
      fbw_row_store = 1'b1;
      fbw_row_swap  = swap_with;
      fm_rdy        = 1'b1;
      @(negedge clk);
      fbw_row_store = 1'b0;
      fbw_row_swap  = 1'b0;
      cyc = 1; beat = 0; low = 0; first = -1;
      while (beat < N_COLS && cyc < 1000) begin
         fm_rdy        = bp ? pat[cyc % 4] : 1'b1;
         disp_vsync    = (cyc == vsync_at);
         fbw_row_store = inject && (cyc == 20);
         fbw_row_swap  = inject && (cyc == 20);
         fbw_row_addr  = (inject && cyc == 20) ? 6'd20 : row;
         fbw_wren      = inject && (cyc >= 2) && (cyc < 2 + N_COLS);
         fbw_col_addr  = 6'(cyc - 2);
         fbw_data      = 24'h300000 + 24'(cyc - 2);
         if (!fbw_row_rdy) low++;
         if (held) begin
            chk("hold_wren", 32'(fm_wren), 32'd1);
            chk("hold_addr", 32'(fm_addr), 32'(h_addr));
            chk("hold_data", 32'(fm_data), 32'(h_data));
         end
         if (fm_wren && first < 0) first = cyc;
         if (fm_wren && fm_rdy) begin
            e_addr = {exp_msb, row, 6'(beat)};
            chk("beat_addr", 32'(fm_addr), 32'(e_addr));
            chk("beat_data", 32'(fm_data), 32'(exp_base + 24'(beat)));
            beat++;
         end
         held   = fm_wren && !fm_rdy;
         h_addr = fm_addr;
         h_data = fm_data;
         @(negedge clk);
         cyc++;
      end
      fm_rdy = 1'b1; disp_vsync = 1'b0; fbw_wren = 1'b0;
      fbw_row_store = 1'b0; fbw_row_swap = 1'b0;
      while (!fbw_row_rdy && cyc < 1000) begin
         low++;
         @(negedge clk);
         cyc++;
      end
      chk("beat_count", 32'(beat), 32'(N_COLS));
      if (exp_first >= 0) chk("first_beat_cycle", 32'(first), 32'(exp_first));
      if (exp_low >= 0) chk("row_rdy_low_cycles", 32'(low), 32'(exp_low));
      for (int k = 0; k < 4; k++) begin
         chk("no_extra_wren", 32'(fm_wren), 32'd0);
         chk("idle_row_rdy", 32'(fbw_row_rdy), 32'd1);
         @(negedge clk);
      end
      $display("store row %0d: %0d beats, first at cycle %0d, row_rdy low %0d cycles",
               row, beat, first, low);
   endtask

   initial begin
      int cyc;
      int beat;

      vecs[0] = '{fill:1, base:24'h000100, swap_before:1, swap_with:0, row:6'd5,
                  bp:0, inject:0, exp_base:24'h000100, exp_first:2, exp_low:65};
      vecs[1] = '{fill:1, base:24'hA50000, swap_before:1, swap_with:0, row:6'd63,
                  bp:1, inject:0, exp_base:24'hA50000, exp_first:2, exp_low:-1};
      vecs[2] = '{fill:1, base:24'hFFFFC0, swap_before:1, swap_with:0, row:6'd0,
                  bp:0, inject:0, exp_base:24'hFFFFC0, exp_first:2, exp_low:65};
      vecs[3] = '{fill:1, base:24'h112200, swap_before:1, swap_with:0, row:6'd10,
                  bp:0, inject:1, exp_base:24'h112200, exp_first:2, exp_low:65};
      vecs[4] = '{fill:0, base:24'h000000, swap_before:1, swap_with:0, row:6'd11,
                  bp:0, inject:0, exp_base:24'h300000, exp_first:2, exp_low:65};
      vecs[5] = '{fill:1, base:24'hABC000, swap_before:0, swap_with:1, row:6'd12,
                  bp:0, inject:0, exp_base:24'hABC000, exp_first:2, exp_low:65};

      rst = 1'b1;
      fbw_row_addr = '0; fbw_row_store = 1'b0; fbw_row_swap = 1'b0;
      fbw_data = '0; fbw_col_addr = '0; fbw_wren = 1'b0;
      frame_swap = 1'b0; disp_vsync = 1'b0; fm_rdy = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_row_rdy", 32'(fbw_row_rdy), 32'd1);
      chk("rst_frame_rdy", 32'(frame_rdy), 32'd1);
      chk("rst_fm_wren", 32'(fm_wren), 32'd0);
      chk("rst_fm_addr", 32'(fm_addr), 32'd0);
      chk("rst_fm_data", 32'(fm_data), 32'd0);
      chk("rst_disp_frame", 32'(disp_frame), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].fill) fill(vecs[i].base);
         if (vecs[i].swap_before) pulse_swap();
         do_store(vecs[i].row, vecs[i].swap_with, vecs[i].bp, vecs[i].inject, -1,
                  vecs[i].exp_base, 1'b0, vecs[i].exp_first, vecs[i].exp_low);
      end

      // Frame flip: request (twice), vsync mid-copy is deferred, next vsync commits.
      frame_swap = 1'b1; @(negedge clk); frame_swap = 1'b0;
      chk("flip_pending", 32'(frame_rdy), 32'd0);
      frame_swap = 1'b1; @(negedge clk); frame_swap = 1'b0;
      chk("flip_pending_again", 32'(frame_rdy), 32'd0);
      fill(24'h070700);
      pulse_swap();
      do_store(6'd7, 1'b0, 1'b0, 1'b0, 10, 24'h070700, 1'b0, 2, 65);
      chk("flip_deferred_rdy", 32'(frame_rdy), 32'd0);
      chk("flip_deferred_frame", 32'(disp_frame), 32'd1);
      disp_vsync = 1'b1; @(negedge clk); disp_vsync = 1'b0;
      chk("flip_commit_rdy", 32'(frame_rdy), 32'd1);
      chk("flip_commit_frame", 32'(disp_frame), 32'd0);
      fill(24'h080800);
      pulse_swap();
      do_store(6'd8, 1'b0, 1'b0, 1'b0, -1, 24'h080800, 1'b1, 2, 65);
      disp_vsync = 1'b1; @(negedge clk); disp_vsync = 1'b0;
      @(negedge clk);
      chk("vsync_no_request_frame", 32'(disp_frame), 32'd0);
      chk("vsync_no_request_rdy", 32'(frame_rdy), 32'd1);

      // Reset after the 10th accepted beat of a copy.
      fill(24'h5A0000);
      pulse_swap();
      fbw_row_addr = 6'd30; fbw_row_store = 1'b1;
      @(negedge clk);
      fbw_row_store = 1'b0;
      cyc = 1; beat = 0;
      while (beat < 10 && cyc < 200) begin
         if (fm_wren) begin
            chk("pre_rst_data", 32'(fm_data), 32'(24'h5A0000 + 24'(beat)));
            beat++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("pre_rst_beats", 32'(beat), 32'd10);
      rst = 1'b1;
      #1;
      chk("midrst_fm_wren", 32'(fm_wren), 32'd0);
      chk("midrst_row_rdy", 32'(fbw_row_rdy), 32'd1);
      chk("midrst_fm_addr", 32'(fm_addr), 32'd0);
      chk("midrst_disp_frame", 32'(disp_frame), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      fill(24'h606000);
      pulse_swap();
      do_store(6'd31, 1'b0, 1'b0, 1'b0, -1, 24'h606000, 1'b0, 2, 65);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_row_sink.md
Name: fb_row_sink

Overview:
- Receiving end of the frame-buffer write interface that the SPI video-stream front end drives.
- Pixel writes land in a ping-pong pair of line buffers. On command, the back line is copied into a double-buffered frame memory at the requested row.
- Frame swaps are committed on the display's vertical sync.
- Supplies the row_rdy / frame_rdy status the host polls over SPI.

Parameters:
- N_ROWS, 64: panel rows; must be a power of 2.
- N_COLS, 64: panel columns; must be a power of 2.
- LOG_N_ROWS, $clog2(N_ROWS): auto-set.
- LOG_N_COLS, $clog2(N_COLS): auto-set.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- fbw_row_addr  in  LOG_N_ROWS  target row; sampled on a store pulse.
- fbw_row_store  in  1  1-cycle pulse: copy back line to frame memory.
- fbw_row_rdy  out  1  high when no row copy is in progress.
- fbw_row_swap  in  1  1-cycle pulse: exchange front and back line buffers.
- fbw_data  in  24  pixel value.
- fbw_col_addr  in  LOG_N_COLS  pixel column.
- fbw_wren  in  1  write fbw_data into the front line at fbw_col_addr.
- frame_swap  in  1  1-cycle pulse: request a frame flip.
- frame_rdy  out  1  low while a frame flip is pending.
- disp_vsync  in  1  1-cycle pulse from scan-out at frame boundary.
- disp_frame  out  1  frame index the scan-out must read (= ~wr_frame).
- fm_addr  out  1+LOG_N_ROWS+LOG_N_COLS  {wr_frame, row, col}.
- fm_data  out  24  frame-memory write data.
- fm_wren  out  1  write valid.
- fm_rdy  in  1  frame memory accepts this cycle; transfer = fm_wren & fm_rdy.

Behaviour:
- Reset values: fbw_row_rdy=1, frame_rdy=1, fm_wren=0, fm_addr=0, fm_data=0, wr_frame=0 (so disp_frame=1), front_sel=0, FSM=IDLE.
- Line buffers: 2 x N_COLS x 24 with 1-cycle synchronous read.
- fbw_wren writes line[front_sel][fbw_col_addr] in any state. Writes are never blocked or dropped.
- Swap, when IDLE: front_sel toggles on the cycle after the pulse.
- Swap, when COPY: ignored. The host must wait for row_rdy.
- Store, when IDLE: row latched, FSM -> COPY, fbw_row_rdy=0 from the next cycle.
- Store, when COPY: ignored.
- Swap and store in the same IDLE cycle: the swap applies first, so the copy reads the buffer that was the front line before the pulse.
- COPY source is the back buffer (~front_sel as of the copy start); the copy never reads the front buffer.
- COPY pipeline: read counter rd_col plus a 1-entry output register (fm_wren = valid).
  - A new read issues when the output register is empty or being accepted this cycle.
  - Data enters the output register 1 cycle after its read.
- With fm_rdy=1 throughout:
  - first fm_wren is 2 cycles after the store pulse;
  - col 0..N_COLS-1 appear on consecutive cycles;
  - fbw_row_rdy rises the cycle after the final accepted write.
- fm_rdy=0 holds fm_addr, fm_data and fm_wren stable. No beat is lost or repeated.
- Column counters wrap at N_COLS. Copy ends after exactly N_COLS accepted beats, then FSM -> IDLE.
- Frame flip:
  - frame_swap sets pending; frame_rdy = ~pending.
  - A frame_swap while pending has no effect.
  - Commit happens on a disp_vsync cycle with pending=1 and FSM=IDLE: wr_frame toggles, pending clears, frame_rdy rises the next cycle.
  - If vsync arrives during COPY, commit waits for the next vsync.
- fm_addr MSB uses the wr_frame value latched at copy start, so a row is never split across frames.
- Reset mid-copy: aborts immediately to reset values. Partially written row data is left in memory.

Decomposition:
- Shared package fb_pkg: pixel width (24), FSM state encoding (IDLE/COPY), and the address-packing helper for {frame,row,col}.
- One sub-module: fb_line_buf, the dual-bank 1-write/1-read synchronous line RAM (bank select + column addressing, BRAM-inferable).
- The FSM, counters and frame-flip logic stay in fb_row_sink.

Test Plan:
- Fill, swap, store row 5 (N_COLS=64, fm_rdy=1):
  - stimulus: write col c = 24'h000100+c, swap, store row 5;
  - response: fm_wren on 64 consecutive cycles starting 2 cycles after the store, fm_addr={0,5,c}, data matches; row_rdy low for exactly 65 cycles.
- Backpressure:
  - stimulus: fm_rdy toggles 1,0,0,1 repeating during a store;
  - response: every column is written exactly once, in order; outputs are stable while fm_rdy=0.
- Busy drops and concurrent writes:
  - stimulus: a store and a swap pulsed mid-copy;
  - response: both are ignored (front_sel unchanged, one copy only); fbw_wren to the front line during the copy lands correctly and does not corrupt the copy.
- Swap+store same cycle:
  - stimulus: pulse both together, with the front line holding pattern A before the pulse;
  - response: the copy writes pattern A.
- Frame flip:
  - stimulus: frame_swap, then vsync during a copy, then vsync after the copy;
  - response: frame_rdy=0 until the second vsync+1; disp_frame goes 1->0; the next store uses fm_addr MSB=1.
- Reset mid-copy:
  - stimulus: assert rst after the 10th beat;
  - response: fm_wren=0 and row_rdy=1 immediately; a subsequent full store completes normally.
